// File: rtl/btn_conditioner_if.sv
// Button conditioner bus: raw buttons and repeat enables in, conditioned levels and pulses out.
interface btn_conditioner_if #(
   parameter int CHANNELS = 4
);
   logic [CHANNELS-1:0] i_btn_in;
   logic [CHANNELS-1:0] i_repeat_en;
   logic [CHANNELS-1:0] o_level;
   logic [CHANNELS-1:0] o_press;
   logic [CHANNELS-1:0] o_release;
   logic [CHANNELS-1:0] o_long_press;
   logic [CHANNELS-1:0] o_repeat;

   modport master (
      output i_btn_in, i_repeat_en,
      input  o_level, o_press, o_release, o_long_press, o_repeat
   );

   modport slave (
      input  i_btn_in, i_repeat_en,
      output o_level, o_press, o_release, o_long_press, o_repeat
   );
endinterface

// File: rtl/btn_conditioner.sv
// Multi-channel push-button front end: synchroniser, counter debouncer, press/release edges,
// and a hold FSM producing a single long-press pulse followed by an optional auto-repeat train.
module btn_conditioner #(
   parameter int CHANNELS        = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int LONG_CYCLES     = 50000000,
   parameter int REPEAT_CYCLES   = 10000000
) (
   input logic              clk,
   input logic              rst,
   btn_conditioner_if.slave bus
);
   localparam int DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
   localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

   // Level flips on the edge that sees DEBOUNCE_CYCLES already counted: D+2 cycles end to end.
   localparam logic [DEB_W-1:0]  DEB_TERM  = DEB_W'(DEBOUNCE_CYCLES);
   localparam logic [HOLD_W-1:0] LONG_TERM = HOLD_W'(LONG_CYCLES - 1);
   localparam logic [HOLD_W-1:0] RPT_TERM  = HOLD_W'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_LONG, ST_REPEAT} hold_state_t;

   logic [CHANNELS-1:0] w_level;
   logic [CHANNELS-1:0] w_press;
   logic [CHANNELS-1:0] w_release;
   logic [CHANNELS-1:0] w_long;
   logic [CHANNELS-1:0] w_repeat;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic              r_s0;
      logic              r_s1;
      logic              r_level;
      logic              r_press;
      logic              r_release;
      logic              r_long;
      logic              r_repeat;
      logic [DEB_W-1:0]  r_deb_cnt;
      logic [HOLD_W-1:0] r_hold_cnt;
      hold_state_t       r_state;
      logic              w_toggle;
      logic              w_fall;

      assign w_toggle = (r_s1 != r_level) && (r_deb_cnt == DEB_TERM);
      assign w_fall   = w_toggle && r_level;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_s0       <= 1'b0;
            r_s1       <= 1'b0;
            r_level    <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
            r_repeat   <= 1'b0;
            r_deb_cnt  <= '0;
            r_hold_cnt <= '0;
            r_state    <= ST_IDLE;
         end else begin
            r_s0      <= bus.i_btn_in[g];
            r_s1      <= r_s0;
            r_press   <= w_toggle && !r_level;
            r_release <= w_fall;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;

            if (r_s1 == r_level) begin
               r_deb_cnt <= '0;
            end else if (w_toggle) begin
               r_level   <= ~r_level;
               r_deb_cnt <= '0;
            end else begin
               r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end

            // Release pre-empts the hold FSM on the same edge so no pulse lands in the release cycle.
            if (w_fall) begin
               r_state    <= ST_IDLE;
               r_hold_cnt <= '0;
            end else begin
               case (r_state)
                  ST_IDLE: begin
                     if (r_press) begin
                        r_state    <= ST_HELD;
                        r_hold_cnt <= HOLD_W'(1);
                     end
                  end
                  ST_HELD: begin
                     if (r_hold_cnt == LONG_TERM) begin
                        r_long     <= 1'b1;
                        r_hold_cnt <= '0;
                        r_state    <= ST_LONG;
                     end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                     end
                  end
                  ST_LONG: begin
                     r_hold_cnt <= '0;
                     if (bus.i_repeat_en[g]) r_state <= ST_REPEAT;
                  end
                  ST_REPEAT: begin
                     if (!bus.i_repeat_en[g]) begin
                        r_state    <= ST_LONG;
                        r_hold_cnt <= '0;
                     end else if (r_hold_cnt == RPT_TERM) begin
                        r_repeat   <= 1'b1;
                        r_hold_cnt <= '0;
                     end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                     end
                  end
                  default: begin
                     r_state    <= ST_IDLE;
                     r_hold_cnt <= '0;
                  end
               endcase
            end
         end
      end

      assign w_level[g]   = r_level;
      assign w_press[g]   = r_press;
      assign w_release[g] = r_release;
      assign w_long[g]    = r_long;
      assign w_repeat[g]  = r_repeat;
   end

   assign bus.o_level      = w_level;
   assign bus.o_press      = w_press;
   assign bus.o_release    = w_release;
   assign bus.o_long_press = w_long;
   assign bus.o_repeat     = w_repeat;
endmodule
